vme_a32_d32_responder: RTL and testbench

- Synthesizable VME64x slave-side responder for single-cycle A32/D32 accesses issued by a VME master on the SVEC backplane.
- Synchronizes the asynchronous VME strobes and decodes the address against a programmable base.
- Runs one local Wishbone-classic transaction per VME cycle, then answers with DTACK, or with BERR on local error or timeout.
- Sits between the VME buffer pins and the application Wishbone crossbar, on clk_sys_i.

---
 rtl/vme_a32_d32_responder_if.sv | 41 ++++
 rtl/vme_a32_d32_responder.sv | 172 +++++++++++++++++
 tb/tb_vme_a32_d32_responder.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vme_a32_d32_responder_if.sv
// VME pin-side and Wishbone-side signal bundle for the A32/D32 responder.
// The responder takes the slave modport; the backplane/crossbar model takes master.
interface vme_a32_d32_responder_if #(
  parameter int unsigned g_WINDOW_BITS = 20
);
  logic                     vme_as_n_i;
  logic [1:0]               vme_ds_n_i;
  logic                     vme_write_n_i;
  logic [5:0]               vme_am_i;
  logic [31:1]              vme_addr_i;
  logic                     vme_lword_n_i;
  logic [31:0]              vme_data_i;
  logic [31:0]              vme_data_o;
  logic                     vme_data_oe_o;
  logic                     vme_dtack_n_o;
  logic                     vme_dtack_oe_o;
  logic                     vme_berr_n_o;
  logic                     wb_cyc_o;
  logic                     wb_stb_o;
  logic                     wb_we_o;
  logic [g_WINDOW_BITS-1:2] wb_adr_o;
  logic [31:0]              wb_dat_o;
  logic [3:0]               wb_sel_o;
  logic [31:0]              wb_dat_i;
  logic                     wb_ack_i;
  logic                     wb_err_i;

  modport slave (
    input  vme_as_n_i, vme_ds_n_i, vme_write_n_i, vme_am_i, vme_addr_i,
           vme_lword_n_i, vme_data_i, wb_dat_i, wb_ack_i, wb_err_i,
    output vme_data_o, vme_data_oe_o, vme_dtack_n_o, vme_dtack_oe_o,
           vme_berr_n_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
  );

  modport master (
    output vme_as_n_i, vme_ds_n_i, vme_write_n_i, vme_am_i, vme_addr_i,
           vme_lword_n_i, vme_data_i, wb_dat_i, wb_ack_i, wb_err_i,
    input  vme_data_o, vme_data_oe_o, vme_dtack_n_o, vme_dtack_oe_o,
           vme_berr_n_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
  );
endinterface

// File: rtl/vme_a32_d32_responder.sv
// VME64x A32/D32 single-cycle slave: synchronizes strobes, decodes a base window,
// runs one Wishbone-classic cycle per VME cycle and answers with DTACK or BERR.
module vme_a32_d32_responder #(
  parameter int unsigned g_WINDOW_BITS = 20,
  parameter int unsigned g_TIMEOUT     = 255,
  parameter int unsigned g_SYNC_STAGES = 2
) (
  input  logic                          clk_sys_i,
  input  logic                          rst_i,
  input  logic [31:0]                   base_addr_i,
  input  logic                          enable_i,
  vme_a32_d32_responder_if.slave        bus_if
);

  localparam int unsigned CNT_RAW = $clog2(g_TIMEOUT + 1);
  localparam int unsigned CNT_W   = (CNT_RAW < 8) ? 8 : CNT_RAW;

  typedef enum logic [3:0] {
    S_IDLE, S_DECODE, S_IGNORE, S_WAIT_DS, S_BUS,
    S_SETUP, S_DTACK, S_BERR, S_RELEASE
  } state_t;

  state_t                       state_q, state_d;
  logic [g_SYNC_STAGES-1:0][3:0] sync_q;
  logic [31:1]                  addr_q, addr_d;
  logic [5:0]                   am_q, am_d;
  logic                         lword_q, lword_d;
  logic [31:0]                  wdata_q, wdata_d;
  logic                         wr_q, wr_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [31:0]                  rdata_q, rdata_d;
  logic                         data_oe_q, data_oe_d;
  logic                         dtack_n_q, dtack_n_d;
  logic                         dtack_oe_q, dtack_oe_d;
  logic                         berr_n_q, berr_n_d;
  logic                         cyc_q, cyc_d;
  logic                         we_q, we_d;
  logic [3:0]                   sel_q, sel_d;

  logic       as_s, wr_s;
  logic [1:0] ds_s;
  logic       access_ok;
  logic       unused_base;

  assign as_s        = sync_q[g_SYNC_STAGES-1][0];
  assign ds_s        = sync_q[g_SYNC_STAGES-1][2:1];
  assign wr_s        = sync_q[g_SYNC_STAGES-1][3];
  assign unused_base = ^base_addr_i[g_WINDOW_BITS-1:0];

  // Strobes are inverted to active-high before entering the synchronizer chain.
  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= ~{bus_if.vme_write_n_i, bus_if.vme_ds_n_i, bus_if.vme_as_n_i};
      for (int i = 1; i < int'(g_SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      am_q       <= '0;
      lword_q    <= 1'b1;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      data_oe_q  <= 1'b0;
      dtack_n_q  <= 1'b1;
      dtack_oe_q <= 1'b0;
      berr_n_q   <= 1'b1;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      am_q       <= am_d;
      lword_q    <= lword_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      data_oe_q  <= data_oe_d;
      dtack_n_q  <= dtack_n_d;
      dtack_oe_q <= dtack_oe_d;
      berr_n_q   <= berr_n_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    am_d    = am_q;
    lword_d = lword_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;

    access_ok = ((am_q == 6'h09) || (am_q == 6'h0D)) && !lword_q && !addr_q[1] &&
                (addr_q[31:g_WINDOW_BITS] == base_addr_i[31:g_WINDOW_BITS]) && enable_i;

    unique case (state_q)
      S_IDLE: begin
        if (as_s) begin
          addr_d  = bus_if.vme_addr_i;
          am_d    = bus_if.vme_am_i;
          lword_d = bus_if.vme_lword_n_i;
          state_d = S_DECODE;
        end
      end
      S_DECODE:  state_d = access_ok ? S_WAIT_DS : S_IGNORE;
      S_IGNORE:  if (!as_s) state_d = S_IDLE;
      S_WAIT_DS: begin
        if (!as_s) begin
          state_d = S_IDLE;
        end else if (&ds_s) begin
          wdata_d = bus_if.vme_data_i;
          wr_d    = wr_s;
          cnt_d   = '0;
          state_d = S_BUS;
        end
      end
      // Error beats ack when both terminate in the same cycle.
      S_BUS: begin
        if (bus_if.wb_err_i || (cnt_q == CNT_W'(g_TIMEOUT - 1))) begin
          state_d = S_BERR;
        end else if (bus_if.wb_ack_i) begin
          if (!wr_q) rdata_d = bus_if.wb_dat_i;
          state_d = S_SETUP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SETUP:           state_d = S_DTACK;
      S_DTACK, S_BERR:   if (ds_s == 2'b00) state_d = S_RELEASE;
      S_RELEASE:         state_d = as_s ? S_WAIT_DS : S_IDLE;
      default:           state_d = S_IDLE;
    endcase

    // Master withdrawing AS mid-transfer: drop any open WB cycle and release the bus.
    if (!as_s && (state_q inside {S_DECODE, S_BUS, S_SETUP, S_DTACK, S_BERR}))
      state_d = S_RELEASE;

    cyc_d      = (state_d == S_BUS);
    we_d       = cyc_d && wr_d;
    sel_d      = cyc_d ? 4'hF : 4'h0;
    data_oe_d  = (state_d inside {S_SETUP, S_DTACK}) && !wr_d;
    dtack_oe_d = state_d inside {S_SETUP, S_DTACK, S_BERR, S_RELEASE};
    dtack_n_d  = (state_d != S_DTACK);
    berr_n_d   = (state_d != S_BERR);
  end

  assign bus_if.vme_data_o     = rdata_q;
  assign bus_if.vme_data_oe_o  = data_oe_q;
  assign bus_if.vme_dtack_n_o  = dtack_n_q;
  assign bus_if.vme_dtack_oe_o = dtack_oe_q;
  assign bus_if.vme_berr_n_o   = berr_n_q;
  assign bus_if.wb_cyc_o       = cyc_q;
  assign bus_if.wb_stb_o       = cyc_q;
  assign bus_if.wb_we_o        = we_q;
  assign bus_if.wb_adr_o       = addr_q[g_WINDOW_BITS-1:2];
  assign bus_if.wb_dat_o       = wdata_q;
  assign bus_if.wb_sel_o       = sel_q;

endmodule

// File: tb/tb_vme_a32_d32_responder.sv
// Directed bench for vme_a32_d32_responder: write, read, decode rejects,
// timeout, ack/err collision, async reset and AS abort.
module tb_vme_a32_d32_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] base_addr = 32'h8000_0000;
  logic        enable = 1'b1;
  int          n_checks = 0;
  int          n_errors = 0;
  int          stb_starts = 0;
  logic        stb_prev = 1'b0;

  vme_a32_d32_responder_if #(.g_WINDOW_BITS(20)) bus_if ();

  vme_a32_d32_responder #(
    .g_WINDOW_BITS(20), .g_TIMEOUT(255), .g_SYNC_STAGES(2)
  ) dut (
    .clk_sys_i  (clk),
    .rst_i      (rst),
    .base_addr_i(base_addr),
    .enable_i   (enable),
    .bus_if     (bus_if)
  );

  always #8 clk = ~clk;

  always @(negedge clk) begin
    if (bus_if.wb_stb_o && !stb_prev) stb_starts++;
    stb_prev = bus_if.wb_stb_o;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic vme_idle();
    bus_if.vme_as_n_i    = 1'b1;
    bus_if.vme_ds_n_i    = 2'b11;
    bus_if.vme_write_n_i = 1'b1;
  endtask

  // AS with address first, DS two cycles later so DS latency is what the bench sees.
  task automatic vme_start(input logic [31:0] addr, input logic [5:0] am,
                           input logic is_write, input logic [31:0] data);
    bus_if.vme_addr_i    = addr[31:1];
    bus_if.vme_am_i      = am;
    bus_if.vme_lword_n_i = 1'b0;
    bus_if.vme_write_n_i = ~is_write;
    bus_if.vme_as_n_i    = 1'b0;
    tick();
    tick();
    bus_if.vme_data_i    = data;
    bus_if.vme_ds_n_i    = 2'b00;
  endtask

  task automatic wait_stb(input string tag, output int cycles);
    cycles = 0;
    while (!bus_if.wb_stb_o && cycles < 20) begin
      tick();
      cycles++;
    end
    check(tag, 32'(bus_if.wb_stb_o), 32'd1);
  endtask

  task automatic release_and_wait(input string tag);
    int n;
    vme_idle();
    n = 0;
    while (!(bus_if.vme_dtack_n_o && bus_if.vme_berr_n_o) && n < 20) begin
      tick();
      n++;
    end
    check(tag, 32'({bus_if.vme_dtack_n_o, bus_if.vme_berr_n_o}), 32'h3);
    repeat (4) tick();
  endtask

  initial begin
    int n;
    int starts0;
    logic bad;
    logic [31:0] bad_addr [3];
    logic [5:0]  bad_am   [3];
    logic        bad_en   [3];

    vme_idle();
    bus_if.vme_am_i      = 6'h00;
    bus_if.vme_addr_i    = '0;
    bus_if.vme_lword_n_i = 1'b1;
    bus_if.vme_data_i    = '0;
    bus_if.wb_dat_i      = '0;
    bus_if.wb_ack_i      = 1'b0;
    bus_if.wb_err_i      = 1'b0;

    repeat (3) tick();
    check("rst_dtack_n",  32'(bus_if.vme_dtack_n_o),  32'd1);
    check("rst_berr_n",   32'(bus_if.vme_berr_n_o),   32'd1);
    check("rst_dtack_oe", 32'(bus_if.vme_dtack_oe_o), 32'd0);
    check("rst_data_oe",  32'(bus_if.vme_data_oe_o),  32'd0);
    check("rst_data",     bus_if.vme_data_o,          32'd0);
    check("rst_wb",       32'({bus_if.wb_cyc_o, bus_if.wb_stb_o, bus_if.wb_we_o, bus_if.wb_sel_o}), 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Write 0xDEADBEEF to 0x80000010
    starts0 = stb_starts;
    vme_start(32'h8000_0010, 6'h09, 1'b1, 32'hDEAD_BEEF);
    wait_stb("wr_stb_seen", n);
    check("wr_ds_to_stb", 32'(n), 32'd3);
    check("wr_cyc", 32'(bus_if.wb_cyc_o), 32'd1);
    check("wr_adr", 32'(bus_if.wb_adr_o), 32'h4);
    check("wr_we",  32'(bus_if.wb_we_o),  32'd1);
    check("wr_dat", bus_if.wb_dat_o,      32'hDEAD_BEEF);
    check("wr_sel", 32'(bus_if.wb_sel_o), 32'hF);
    bus_if.wb_ack_i = 1'b1;
    tick();
    bus_if.wb_ack_i = 1'b0;
    check("wr_stb_drop",  32'(bus_if.wb_stb_o),       32'd0);
    check("wr_setup_oe",  32'(bus_if.vme_dtack_oe_o), 32'd1);
    check("wr_setup_dtk", 32'(bus_if.vme_dtack_n_o),  32'd1);
    check("wr_data_oe",   32'(bus_if.vme_data_oe_o),  32'd0);
    tick();
    check("wr_dtack_low", 32'(bus_if.vme_dtack_n_o),  32'd0);
    repeat (2) tick();
    check("wr_dtack_hold", 32'(bus_if.vme_dtack_n_o), 32'd0);
    vme_idle();
    n = 0;
    while (!bus_if.vme_dtack_n_o && n < 20) begin
      tick();
      n++;
    end
    check("wr_dtack_rel",  32'(bus_if.vme_dtack_n_o),  32'd1);
    check("wr_rel_oe",     32'(bus_if.vme_dtack_oe_o), 32'd1);
    tick();
    check("wr_idle_oe",    32'(bus_if.vme_dtack_oe_o), 32'd0);
    check("wr_one_cycle",  32'(stb_starts - starts0),  32'd1);
    repeat (3) tick();

    // Read from 0x800FFFFC, slave acks on the fourth cycle
    vme_start(32'h800F_FFFC, 6'h0D, 1'b0, 32'h0);
    wait_stb("rd_stb_seen", n);
    check("rd_adr", 32'(bus_if.wb_adr_o), 32'h3FFFF);
    check("rd_we",  32'(bus_if.wb_we_o),  32'd0);
    repeat (3) tick();
    check("rd_stb_wait", 32'(bus_if.wb_stb_o), 32'd1);
    bus_if.wb_dat_i = 32'h1234_5678;
    bus_if.wb_ack_i = 1'b1;
    tick();
    bus_if.wb_ack_i = 1'b0;
    bus_if.wb_dat_i = 32'h0;
    check("rd_data",      bus_if.vme_data_o,         32'h1234_5678);
    check("rd_oe_early",  32'(bus_if.vme_data_oe_o), 32'd1);
    check("rd_dtack_pre", 32'(bus_if.vme_dtack_n_o), 32'd1);
    tick();
    check("rd_dtack_low", 32'(bus_if.vme_dtack_n_o), 32'd0);
    check("rd_oe_dtack",  32'(bus_if.vme_data_oe_o), 32'd1);
    release_and_wait("rd_release");
    check("rd_oe_off",    32'(bus_if.vme_data_oe_o), 32'd0);

    // Decode rejects: wrong base, wrong AM, disabled
    bad_addr = '{32'h9000_0000, 32'h8000_0000, 32'h8000_0000};
    bad_am   = '{6'h09, 6'h39, 6'h09};
    bad_en   = '{1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      starts0 = stb_starts;
      enable = bad_en[k];
      vme_start(bad_addr[k], bad_am[k], 1'b1, 32'h5555_AAAA);
      bad = 1'b0;
      for (int c = 0; c < 12; c++) begin
        tick();
        if (bus_if.wb_cyc_o || bus_if.wb_stb_o || bus_if.vme_dtack_oe_o ||
            bus_if.vme_data_oe_o || !bus_if.vme_dtack_n_o || !bus_if.vme_berr_n_o)
          bad = 1'b1;
      end
      check($sformatf("reject%0d_quiet", k), 32'(bad), 32'd0);
      check($sformatf("reject%0d_nowb", k),  32'(stb_starts - starts0), 32'd0);
      vme_idle();
      repeat (4) tick();
    end
    enable = 1'b1;

    // Timeout: nobody answers
    vme_start(32'h8000_0040, 6'h09, 1'b1, 32'h1111_2222);
    wait_stb("to_stb_seen", n);
    n = 0;
    while (bus_if.wb_stb_o && n < 400) begin
      n++;
      tick();
    end
    check("to_stb_len", 32'(n), 32'd255);
    check("to_berr",    32'(bus_if.vme_berr_n_o),  32'd0);
    check("to_oe",      32'(bus_if.vme_dtack_oe_o), 32'd1);
    check("to_dtack",   32'(bus_if.vme_dtack_n_o),  32'd1);
    repeat (3) tick();
    check("to_berr_hold", 32'(bus_if.vme_berr_n_o), 32'd0);
    release_and_wait("to_release");

    // ack and err together: error wins
    vme_start(32'h8000_0080, 6'h09, 1'b0, 32'h0);
    wait_stb("ae_stb_seen", n);
    bus_if.wb_ack_i = 1'b1;
    bus_if.wb_err_i = 1'b1;
    tick();
    bus_if.wb_ack_i = 1'b0;
    bus_if.wb_err_i = 1'b0;
    check("ae_berr",  32'(bus_if.vme_berr_n_o),  32'd0);
    check("ae_dtack", 32'(bus_if.vme_dtack_n_o), 32'd1);
    tick();
    check("ae_dtack2", 32'({bus_if.vme_dtack_n_o, bus_if.vme_data_oe_o}), 32'h2);
    release_and_wait("ae_release");

    // Async reset while DTACK is asserted
    vme_start(32'h8000_0100, 6'h09, 1'b1, 32'hCAFE_0001);
    wait_stb("rs_stb_seen", n);
    bus_if.wb_ack_i = 1'b1;
    tick();
    bus_if.wb_ack_i = 1'b0;
    tick();
    check("rs_in_dtack", 32'(bus_if.vme_dtack_n_o), 32'd0);
    rst = 1'b1;
    #1;
    check("rs_dtack_n", 32'({bus_if.vme_dtack_n_o, bus_if.vme_berr_n_o}), 32'h3);
    check("rs_oe",      32'({bus_if.vme_dtack_oe_o, bus_if.vme_data_oe_o}), 32'h0);
    check("rs_wb",      32'({bus_if.wb_cyc_o, bus_if.wb_stb_o, bus_if.wb_we_o}), 32'h0);
    vme_idle();
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();

    // AS withdrawn during BUS, then a late ack
    vme_start(32'h8000_0200, 6'h09, 1'b1, 32'hCAFE_0002);
    wait_stb("ab_stb_seen", n);
    vme_idle();
    n = 0;
    while (bus_if.wb_stb_o && n < 10) begin
      tick();
      n++;
    end
    check("ab_stb_drop", 32'(bus_if.wb_cyc_o), 32'd0);
    check("ab_rel_oe",   32'(bus_if.vme_dtack_oe_o), 32'd1);
    check("ab_rel_lvls", 32'({bus_if.vme_dtack_n_o, bus_if.vme_berr_n_o}), 32'h3);
    bus_if.wb_ack_i = 1'b1;
    tick();
    bus_if.wb_ack_i = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (!bus_if.vme_dtack_n_o || bus_if.vme_dtack_oe_o) bad = 1'b1;
      tick();
    end
    check("ab_late_ack", 32'(bad), 32'd0);

    // A clean access still works afterwards
    vme_start(32'h8000_0020, 6'h09, 1'b1, 32'h0BAD_F00D);
    wait_stb("fin_stb_seen", n);
    check("fin_adr", 32'(bus_if.wb_adr_o), 32'h8);
    check("fin_dat", bus_if.wb_dat_o,      32'h0BAD_F00D);
    bus_if.wb_ack_i = 1'b1;
    tick();
    bus_if.wb_ack_i = 1'b0;
    tick();
    check("fin_dtack", 32'(bus_if.vme_dtack_n_o), 32'd0);
    release_and_wait("fin_release");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
